// File: rtl/srl_fifo_read_stage.sv
// srl_fifo_read_stage
//
// SRL-based dataflow-channel FIFO with a registered show-ahead read stage.
// A DEPTH-entry shift-register array holds queued words. The oldest word is
// moved into an output register, so the consumer sees flop-driven
// if_dout/if_empty_n. Total capacity is DEPTH+1 words: DEPTH in the array
// plus one in the output stage.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   if_full_n    1 = a write is accepted this cycle (registered)
//   if_write_ce  write clock-enable
//   if_write     write request
//   if_din       write data
//   if_empty_n   1 = if_dout holds a valid head-of-queue word (registered)
//   if_read_ce   read clock-enable
//   if_read      read request
//   if_dout      head-of-queue data (registered)
module srl_fifo_read_stage #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
);

  // Counter must represent 0..DEPTH inclusive.
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] srl_mem [DEPTH];
  logic [CNT_W-1:0]      srl_cnt;
  logic [CNT_W-1:0]      srl_cnt_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  out_valid;
  logic                  out_valid_next;
  logic                  push;
  logic                  pop;
  logic                  load;

  // Handshakes qualify on the registered flags, so requests made while
  // full or empty are simply dropped.
  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read  & if_read_ce  & out_valid;

  // Refill the output stage whenever it is empty or being drained this cycle.
  assign load = (srl_cnt != '0) & (~out_valid | pop);

  // Oldest entry sits at srl_cnt-1. The read uses the pre-shift count, which
  // stays correct on a simultaneous push+load: the shift moves the next-oldest
  // word up by one while the count is unchanged.
  assign rd_addr = ADDR_WIDTH'(srl_cnt - CNT_W'(1));
  assign rd_data = srl_mem[rd_addr];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    srl_cnt_next   = srl_cnt;
    out_valid_next = out_valid;

    srl_cnt_next = srl_cnt + CNT_W'(push) - CNT_W'(load);

    if (load) begin
      out_valid_next = 1'b1;
    end else if (pop) begin
      out_valid_next = 1'b0;
    end
  end

  // Storage shifts on push. It has no reset: stale contents are unreachable
  // once srl_cnt is cleared.
  // NOTE: the data array is deliberately left out of reset; a reset on a
  // memory prevents SRL/RAM mapping and buys nothing here.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        srl_mem[i] <= srl_mem[i-1];
      end
      srl_mem[0] <= if_din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that all flops
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srl_cnt   <= '0;
      out_valid <= 1'b0;
      if_full_n <= 1'b1;
      if_dout   <= '0;
    end else begin
      srl_cnt   <= srl_cnt_next;
      out_valid <= out_valid_next;
      if_full_n <= (srl_cnt_next != CNT_W'(DEPTH));
      if (load) begin
        if_dout <= rd_data;
      end
    end
  end

  assign if_empty_n = out_valid;

endmodule

// File: tb/tb_srl_fifo_read_stage.sv
// Self-checking bench for srl_fifo_read_stage (DEPTH=2, 8-bit payload).
// Hand-computed vector table, hand-written multi-cycle sequences, and a
// randomized run against a queue-based reference model.
module tb_srl_fifo_read_stage;

  localparam int DW    = 8;
  localparam int AW    = 1;
  localparam int DEPTH = 2;

  logic          clk;
  logic          reset;
  logic          if_full_n;
  logic          if_write_ce;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_empty_n;
  logic          if_read_ce;
  logic          if_read;
  logic [DW-1:0] if_dout;

  int total = 0;
  int bad   = 0;

  srl_fifo_read_stage #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_full_n   (if_full_n),
    .if_write_ce (if_write_ce),
    .if_write    (if_write),
    .if_din      (if_din),
    .if_empty_n  (if_empty_n),
    .if_read_ce  (if_read_ce),
    .if_read     (if_read),
    .if_dout     (if_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every stored word in arrival order. m_shown means the
  // front word has reached the consumer-visible output register.
  logic [DW-1:0] mq[$];
  bit            m_shown;
  logic [DW-1:0] m_dout;
  bit            m_full_n;

  typedef struct {
    bit            w;
    bit            wce;
    logic [DW-1:0] din;
    bit            r;
    bit            rce;
    bit            exp_full_n;
    bit            exp_empty_n;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_shown  = 1'b0;
    m_dout   = '0;
    m_full_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".full_n"},  {31'b0, if_full_n},  {31'b0, m_full_n});
    check({tag, ".empty_n"}, {31'b0, if_empty_n}, {31'b0, m_shown});
    check({tag, ".dout"},    {24'b0, if_dout},    {24'b0, m_dout});
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1ns after the edge.
  task automatic step(input bit w, input bit wce, input logic [DW-1:0] d,
                      input bit r, input bit rce);
    bit do_push, do_pop, do_load;
    int in_array;
    if_write    = w;
    if_write_ce = wce;
    if_din      = d;
    if_read     = r;
    if_read_ce  = rce;

    do_push  = w && wce && m_full_n;
    do_pop   = r && rce && m_shown;
    in_array = mq.size() - int'(m_shown);
    do_load  = (in_array > 0) && (!m_shown || do_pop);
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(d);
    if (do_load) begin
      m_shown = 1'b1;
      m_dout  = mq[0];
    end else if (do_pop) begin
      m_shown = 1'b0;
    end
    m_full_n = ((mq.size() - int'(m_shown)) != DEPTH);

    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic add_vec(input bit w, input bit wce, input logic [DW-1:0] d,
                         input bit r, input bit rce,
                         input bit fn, input bit en, input logic [DW-1:0] dout);
    vec_t v;
    v.w = w; v.wce = wce; v.din = d; v.r = r; v.rce = rce;
    v.exp_full_n = fn; v.exp_empty_n = en; v.exp_dout = dout;
    vecs.push_back(v);
  endtask

  initial begin
    int            exp_next;
    int            got;
    bit            seen_other;
    logic [DW-1:0] wd;

    if_write = 0; if_write_ce = 0; if_din = '0; if_read = 0; if_read_ce = 0;
    model_reset();

    // ---------------- reset / idle ----------------
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset.empty_n", {31'b0, if_empty_n}, 32'd0);
    check("reset.full_n",  {31'b0, if_full_n},  32'd1);
    check("reset.dout",    {24'b0, if_dout},    32'd0);
    repeat (2) idle();
    check_model("idle");

    // ---------------- table: latency, fill/drain, CE gating ----------------
    //      w  wce din    r  rce  full_n empty_n dout
    add_vec(1, 1, 8'h01, 0, 0,   1, 0, 8'h00); // push 1 into empty FIFO
    add_vec(0, 0, 8'h00, 0, 0,   1, 1, 8'h01); // visible after next edge
    add_vec(0, 0, 8'h00, 1, 1,   1, 0, 8'h01); // pop -> empty, dout held
    add_vec(1, 1, 8'h01, 0, 0,   1, 0, 8'h01); // fill: push 1
    add_vec(1, 1, 8'h02, 0, 0,   1, 1, 8'h01); // push 2, 1 loaded
    add_vec(1, 1, 8'h03, 0, 0,   0, 1, 8'h01); // push 3 -> full
    add_vec(1, 1, 8'h04, 0, 0,   0, 1, 8'h01); // push 4 ignored
    add_vec(0, 0, 8'h00, 1, 1,   1, 1, 8'h02); // drain 1
    add_vec(0, 0, 8'h00, 1, 1,   1, 1, 8'h03); // drain 2
    add_vec(0, 0, 8'h00, 1, 1,   1, 0, 8'h03); // drain 3 -> empty
    add_vec(1, 1, 8'h05, 0, 0,   1, 0, 8'h03); // push 5
    add_vec(0, 0, 8'h00, 0, 0,   1, 1, 8'h05); // 5 loaded
    add_vec(1, 0, 8'h06, 0, 0,   1, 1, 8'h05); // write without CE: ignored
    add_vec(0, 0, 8'h00, 1, 0,   1, 1, 8'h05); // read without CE: ignored
    add_vec(0, 1, 8'h07, 0, 1,   1, 1, 8'h05); // CEs without requests
    add_vec(0, 0, 8'h00, 1, 1,   1, 0, 8'h05); // real pop -> empty
    add_vec(1, 0, 8'h08, 1, 0,   1, 0, 8'h05); // nothing enabled
    add_vec(0, 0, 8'h00, 1, 1,   1, 0, 8'h05); // pop on empty ignored

    foreach (vecs[i]) begin
      step(vecs[i].w, vecs[i].wce, vecs[i].din, vecs[i].r, vecs[i].rce);
      check($sformatf("vec%0d.full_n", i),  {31'b0, if_full_n},  {31'b0, vecs[i].exp_full_n});
      check($sformatf("vec%0d.empty_n", i), {31'b0, if_empty_n}, {31'b0, vecs[i].exp_empty_n});
      check($sformatf("vec%0d.dout", i),    {24'b0, if_dout},    {24'b0, vecs[i].exp_dout});
    end

    // ---------------- streaming 0..99 with continuous read ----------------
    exp_next = 0;
    for (int c = 0; c < 104; c++) begin
      if (if_empty_n) begin
        check("stream.data", {24'b0, if_dout}, exp_next);
        exp_next++;
      end
      if (c < 100) step(1'b1, 1'b1, DW'(c), 1'b1, 1'b1);
      else         step(1'b0, 1'b0, '0,     1'b1, 1'b1);
      if (c < 100) check("stream.full_n", {31'b0, if_full_n}, 32'd1);
    end
    check("stream.count", exp_next, 32'd100);
    check("stream.empty_after", {31'b0, if_empty_n}, 32'd0);

    // ---------------- mid-operation asynchronous reset ----------------
    step(1'b1, 1'b1, 8'h07, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h08, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h09, 1'b0, 1'b0);
    check("full.full_n",  {31'b0, if_full_n},  32'd0);
    check("full.empty_n", {31'b0, if_empty_n}, 32'd1);
    check("full.dout",    {24'b0, if_dout},    32'h07);
    if_write = 0; if_write_ce = 0;
    #2;                     // mid-cycle, away from any edge
    reset = 1'b1;
    model_reset();
    #1;
    check("arst.empty_n", {31'b0, if_empty_n}, 32'd0);
    check("arst.full_n",  {31'b0, if_full_n},  32'd1);
    check("arst.dout",    {24'b0, if_dout},    32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    check_model("post_rst_idle");
    step(1'b1, 1'b1, 8'h0A, 1'b0, 1'b0);
    got = 0;
    seen_other = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (if_empty_n) begin
        if (if_dout !== 8'h0A) seen_other = 1'b1;
        got++;
      end
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    end
    check("rst_flush.reads",  got, 32'd1);
    check("rst_flush.stale",  {31'b0, seen_other}, 32'd0);
    check("rst_flush.dout",   {24'b0, if_dout},    32'h0A);

    // ---------------- randomized against the model ----------------
    for (int c = 0; c < 3000; c++) begin
      wd = DW'($urandom);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), wd,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) != 0));
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
